// File: rtl/tx_buffer_multi.sv
// Multi-channel FX2 TX packet buffer: SOP-tagged FIFO, I/Q deinterleave, double-buffered sample vector.
// Optional underrun event counter enabled by defining TX_BUFFER_MULTI_UNDERRUN_CNT_EN.
module tx_buffer_multi #(
  parameter int NUM_CHAN     = 4,
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 11,
  parameter int PKT_WORDS    = 256,
  parameter int SPACE_MARGIN = 256
) (
  input  logic                         usbclk,
  input  logic                         reset,
  input  logic                         bus_reset,
  input  logic [DWIDTH-1:0]            usbdata,
  input  logic                         WR,
  output logic                         have_space,
  input  logic                         clear_status,
  input  logic [4:0]                   channels,
  input  logic                         txstrobe,
  output logic [2*NUM_CHAN*DWIDTH-1:0] tx_data,
  output logic                         tx_valid,
  output logic                         tx_empty,
  output logic [AWIDTH:0]              fifo_level,
  output logic                         tx_underrun,
  output logic                         tx_overflow,
`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
  output logic [15:0]                  underrun_count,
`endif
  output logic                         sync_err
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int SLOTS = 2 * NUM_CHAN;
  localparam int WCW   = $clog2(PKT_WORDS + 1);

  logic              wr_reg, sop_reg, sop_arm;
  logic [DWIDTH-1:0] data_reg;
  logic [WCW-1:0]    wcount;

  // sop_arm stays low after a reset taken mid-burst so the tail of that burst is not mistaken for a new packet.
  always_ff @(posedge usbclk) begin
    if (reset) begin
      wr_reg   <= 1'b0;
      sop_reg  <= 1'b0;
      data_reg <= '0;
      wcount   <= '0;
      sop_arm  <= ~WR;
    end else begin
      data_reg <= usbdata;
      sop_arm  <= sop_arm | ~WR;
      if (bus_reset) begin
        wr_reg  <= 1'b0;
        sop_reg <= 1'b0;
        wcount  <= '0;
      end else begin
        wr_reg  <= WR;
        sop_reg <= WR & ~wr_reg & sop_arm;
        if (!wr_reg)
          wcount <= '0;
        else if (wcount != WCW'(PKT_WORDS))
          wcount <= wcount + WCW'(1);
      end
    end
  end

  logic [DWIDTH:0]   mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   level;
  logic              want_push, push, pop, full, empty;
  logic [DWIDTH:0]   head;
  logic              head_sop;
  logic [DWIDTH-1:0] head_data;

  assign want_push = wr_reg & (wcount < WCW'(PKT_WORDS));
  assign full      = (level == (AWIDTH+1)'(DEPTH));
  assign empty     = (level == '0);
  assign push      = want_push & ~full;
  assign head      = mem[rd_ptr];
  assign head_sop  = head[DWIDTH];
  assign head_data = head[DWIDTH-1:0];

  always_ff @(posedge usbclk) begin
    if (push)
      mem[wr_ptr] <= {sop_reg, data_reg};
  end

  always_ff @(posedge usbclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + AWIDTH'(1);
      if (push && !pop)
        level <= level + (AWIDTH+1)'(1);
      else if (pop && !push)
        level <= level - (AWIDTH+1)'(1);
    end
  end

  logic [4:0]        phase, eff_phase, slot_idx;
  logic              present, underrun_evt, resync, overflow_evt;
  logic [DWIDTH-1:0] shadow [SLOTS];

  // A vector handed out this cycle frees the gather, so the next pop lands in slot 0 immediately.
  assign present      = txstrobe & (phase == channels) & (channels != 5'd0);
  assign underrun_evt = txstrobe & (phase != channels);
  assign eff_phase    = present ? 5'd0 : phase;
  assign pop          = ~empty & (channels != 5'd0) & ((phase != channels) | present);
  assign slot_idx     = head_sop ? 5'd0 : eff_phase;
  assign resync       = pop & head_sop & (eff_phase != 5'd0);
  assign overflow_evt = want_push & full;

  always_ff @(posedge usbclk) begin
    if (reset) begin
      phase    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      for (int k = 0; k < SLOTS; k++)
        shadow[k] <= '0;
    end else begin
      tx_valid <= present;
      if (present)
        for (int k = 0; k < SLOTS; k++)
          tx_data[k*DWIDTH +: DWIDTH] <= (5'(k) < channels) ? shadow[k] : '0;
      if (pop) begin
        for (int k = 0; k < SLOTS; k++)
          if (slot_idx == 5'(k))
            shadow[k] <= head_data;
        phase <= slot_idx + 5'd1;
      end else if (present) begin
        phase <= '0;
      end
    end
  end

  always_ff @(posedge usbclk) begin
    if (reset) begin
      have_space  <= 1'b0;
      tx_underrun <= 1'b0;
      tx_overflow <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      have_space  <= (level < (AWIDTH+1)'(DEPTH - SPACE_MARGIN));
      tx_underrun <= underrun_evt | (tx_underrun & ~clear_status);
      tx_overflow <= overflow_evt | (tx_overflow & ~clear_status);
      sync_err    <= resync | (sync_err & ~clear_status);
    end
  end

`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
  always_ff @(posedge usbclk) begin
    if (reset)
      underrun_count <= '0;
    else if (underrun_evt)
      underrun_count <= clear_status ? 16'd1 :
                        (underrun_count == 16'hFFFF) ? underrun_count : underrun_count + 16'd1;
    else if (clear_status)
      underrun_count <= '0;
  end
`endif

  assign tx_empty   = empty;
  assign fifo_level = level;

endmodule

// File: tb/tb_tx_buffer_multi.sv
// Directed bench for tx_buffer_multi at default parameters; checks underrun_count when
// TX_BUFFER_MULTI_UNDERRUN_CNT_EN is defined.
module tb_tx_buffer_multi;

  logic         usbclk = 1'b0;
  logic         reset = 1'b1;
  logic         bus_reset = 1'b0;
  logic [15:0]  usbdata = '0;
  logic         WR = 1'b0;
  logic         have_space;
  logic         clear_status = 1'b0;
  logic [4:0]   channels = 5'd4;
  logic         txstrobe = 1'b0;
  logic [127:0] tx_data;
  logic         tx_valid, tx_empty;
  logic [11:0]  fifo_level;
  logic         tx_underrun, tx_overflow, sync_err;
`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
  logic [15:0]  underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  tx_buffer_multi dut (
    .usbclk(usbclk), .reset(reset), .bus_reset(bus_reset), .usbdata(usbdata), .WR(WR),
    .have_space(have_space), .clear_status(clear_status), .channels(channels),
    .txstrobe(txstrobe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_empty(tx_empty),
    .fifo_level(fifo_level), .tx_underrun(tx_underrun), .tx_overflow(tx_overflow),
`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
    .underrun_count(underrun_count),
`endif
    .sync_err(sync_err)
  );

  always #5 usbclk = ~usbclk;

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_reset(input logic [4:0] chan);
    WR = 1'b0; txstrobe = 1'b0; clear_status = 1'b0; channels = chan;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_burst(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      WR = 1'b1;
      usbdata = base + 16'(i);
      tick();
    end
    WR = 1'b0;
    repeat (3) tick();
  endtask

  logic [127:0] expv;
  logic [127:0] vec_a;
  int nvec, peak, npulse;

  initial begin
    // Reset state with channels = 4.
    tick(); tick();
    check_output("reset_level", 128'(fifo_level), 128'd0);
    check_output("reset_have_space", 128'(have_space), 128'd0);
    check_output("reset_tx_valid", 128'(tx_valid), 128'd0);
    check_output("reset_tx_data", tx_data, 128'd0);
    check_output("reset_flags", 128'({tx_underrun, tx_overflow, sync_err}), 128'd0);
    reset = 1'b0;
    tick();
    check_output("have_space_after_reset", 128'(have_space), 128'd1);

    // 256-word burst, strobes every 8 cycles once the first vector is gathered.
    nvec = 0;
    for (int c = 0; c < 540; c++) begin
      WR = (c < 256);
      usbdata = 16'(c);
      txstrobe = (c >= 16) && (c % 8 == 0) && (nvec < 64);
      tick();
      if (tx_valid) begin
        expv = '0;
        for (int j = 0; j < 4; j++)
          expv[j*16 +: 16] = 16'(4*nvec + j);
        check_output($sformatf("burst_vec%0d", nvec), tx_data, expv);
        nvec++;
      end
    end
    txstrobe = 1'b0;
    check_output("burst_vec_count", 128'(nvec), 128'd64);
    check_output("burst_flags", 128'({tx_underrun, tx_overflow, sync_err}), 128'd0);
    check_output("burst_drained", 128'({tx_empty, fifo_level}), {116'd0, 1'b1, 12'd0});

    // channels = 0: 257-word burst stores 256 words, strobes ignored.
    do_reset(5'd0);
    peak = 0; npulse = 0;
    for (int c = 0; c < 264; c++) begin
      WR = (c < 257);
      usbdata = 16'h1000 + 16'(c);
      txstrobe = (c % 8 == 4);
      tick();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (tx_valid) npulse++;
    end
    WR = 1'b0; txstrobe = 1'b0;
    check_output("pkt257_peak", 128'(peak), 128'd256);
    check_output("pkt257_level", 128'(fifo_level), 128'd256);
    check_output("pkt257_overflow", 128'(tx_overflow), 128'd0);
    check_output("ch0_no_underrun", 128'(tx_underrun), 128'd0);
    check_output("ch0_no_valid", 128'(npulse), 128'd0);
    check_output("ch0_tx_data", tx_data, 128'd0);

    // Fill to 2048 and probe the have_space threshold at 1792.
    for (int b = 0; b < 5; b++)
      write_burst(256, 16'h2000);
    check_output("fill_level_1536", 128'(fifo_level), 128'd1536);
    write_burst(255, 16'h3000);
    check_output("fill_level_1791", 128'(fifo_level), 128'd1791);
    check_output("have_space_1791", 128'(have_space), 128'd1);
    write_burst(1, 16'h3100);
    check_output("fill_level_1792", 128'(fifo_level), 128'd1792);
    check_output("have_space_1792", 128'(have_space), 128'd0);
    write_burst(256, 16'h4000);
    check_output("fill_level_2048", 128'(fifo_level), 128'd2048);
    check_output("full_no_overflow", 128'(tx_overflow), 128'd0);
    write_burst(3, 16'h5000);
    check_output("overflow_set", 128'(tx_overflow), 128'd1);
    check_output("overflow_level", 128'(fifo_level), 128'd2048);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    check_output("overflow_cleared", 128'(tx_overflow), 128'd0);

    // Short packet followed by a new SOP: resync to slot 0.
    do_reset(5'd4);
    write_burst(3, 16'h0300);
    write_burst(4, 16'hA000);
    check_output("sync_err_set", 128'(sync_err), 128'd1);
    vec_a = {64'd0, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    check_output("resync_valid", 128'(tx_valid), 128'd1);
    check_output("resync_vec", tx_data, vec_a);
    check_output("resync_no_underrun", 128'(tx_underrun), 128'd0);

    // Underrun with empty FIFO.
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    check_output("underrun_set", 128'(tx_underrun), 128'd1);
    check_output("underrun_no_valid", 128'(tx_valid), 128'd0);
    check_output("underrun_data_held", tx_data, vec_a);
    tick();
    repeat (2) begin
      txstrobe = 1'b1; tick(); txstrobe = 1'b0; tick();
    end
`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
    check_output("underrun_count_3", 128'(underrun_count), 128'd3);
`endif
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    check_output("underrun_cleared", 128'({tx_underrun, sync_err}), 128'd0);
    txstrobe = 1'b1; clear_status = 1'b1; tick(); txstrobe = 1'b0; clear_status = 1'b0;
    check_output("underrun_set_wins", 128'(tx_underrun), 128'd1);
`ifdef TX_BUFFER_MULTI_UNDERRUN_CNT_EN
    check_output("underrun_count_clr_inc", 128'(underrun_count), 128'd1);
`endif

    // channels = 2: upper slots zero, back-to-back strobe/refill loses nothing.
    do_reset(5'd2);
    write_burst(8, 16'h2000);
    for (int v = 0; v < 4; v++) begin
      txstrobe = 1'b1; tick(); txstrobe = 1'b0;
      expv = {96'd0, 16'h2001 + 16'(2*v), 16'h2000 + 16'(2*v)};
      check_output($sformatf("ch2_valid%0d", v), 128'(tx_valid), 128'd1);
      check_output($sformatf("ch2_vec%0d", v), tx_data, expv);
      tick();
    end
    check_output("ch2_no_underrun", 128'(tx_underrun), 128'd0);
    check_output("ch2_drained", 128'(fifo_level), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_buffer_multi.md
Name: tx_buffer_multi

Overview:
- Parametrised successor to the FX2 TX packet buffer.
- Accepts 16-bit-class words from the FX2 write strobe and stores them, tagged with a start-of-packet bit, in an internal single-clock FIFO.
- Deinterleaves the FIFO into up to NUM_CHAN I/Q pairs and presents a double-buffered sample vector on each txstrobe.
- Adds packet-boundary resynchronisation, overflow detection and sticky status flags; sits between the USB interface and the TX DSP chain in the usbclk domain.

Parameters:
- NUM_CHAN, 4, maximum I/Q channel pairs (1..8).
- DWIDTH, 16, sample/bus word width.
- AWIDTH, 11, FIFO address bits; depth = 2^AWIDTH words.
- PKT_WORDS, 256, words accepted per WR burst; excess words are dropped (FX2 257-word fix).
- SPACE_MARGIN, 256, free-word margin for have_space.

Ports:
- usbclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- bus_reset  in  1  synchronous; clears write-side burst counter and SOP detector only.
- usbdata  in  DWIDTH  FX2 write data.
- WR  in  1  FX2 write strobe; high for one burst.
- have_space  out  1  registered; FIFO can accept another packet.
- clear_status  in  1  clears sticky flags.
- channels  in  5  words per sample vector; legal values 0, 2, 4 .. 2*NUM_CHAN; static outside reset.
- txstrobe  in  1  DSP sample request, one-cycle pulse.
- tx_data  out  2*NUM_CHAN*DWIDTH  slot k at bits [k*DWIDTH +: DWIDTH]; order i0, q0, i1, q1, ...
- tx_valid  out  1  one-cycle pulse when tx_data is updated.
- tx_empty  out  1  FIFO empty.
- fifo_level  out  AWIDTH+1  current occupancy.
- tx_underrun  out  1  sticky.
- tx_overflow  out  1  sticky.
- sync_err  out  1  sticky.

Behaviour:
- Reset values: have_space 0, all other outputs 0, phase 0, FIFO empty.
- Input stage:
  - wr_reg, data_reg are registered copies of WR and usbdata.
  - sop_reg = WR & ~wr_reg.
  - wcount increments while wr_reg is high. It clears when wr_reg is low or on bus_reset, and saturates at PKT_WORDS.
- Write: push {sop_reg, data_reg} when wr_reg & wcount < PKT_WORDS & ~full.
  - If a push is required but the FIFO is full, drop the word and set tx_overflow.
  - Words at or beyond PKT_WORDS are dropped silently with no flag.
- Read side is show-ahead: head word is visible combinationally; a pop takes effect at the clock edge.
- Simultaneous push and pop: level is unchanged; write and read of the same address are never required when level is 0.
- have_space <= (fifo_level < 2^AWIDTH − SPACE_MARGIN), registered one cycle.
- Gather: the shadow register holds 2*NUM_CHAN slots, phase counts 0..channels.
  - When phase != channels & ~tx_empty: pop, write head word to shadow[phase], phase++.
  - Resync: if a popped word has sop=1 and phase != 0, set sync_err, write the word to shadow[0] and set phase to 1. The partial vector is discarded.
- Present: when txstrobe & phase == channels, copy shadow to tx_data, pulse tx_valid next cycle, and set phase to 0.
  - Slots ≥ channels always output 0.
  - Gathering may restart in the same cycle the strobe is accepted.
- Underrun: txstrobe & phase != channels sets tx_underrun; tx_data holds its previous value and tx_valid stays low.
- channels = 0: no pops, tx_data stays 0, txstrobe is ignored and no underrun is flagged.
- Sticky flags: clear_status clears all three; a set in the same cycle wins over the clear.
- Reset mid-burst: FIFO flushed. Words from the rest of the burst are written as non-SOP; the next SOP realigns and flags sync_err if it arrives mid-vector.

Optional Feature:
- TX_BUFFER_MULTI_UNDERRUN_CNT_EN defined:
  - Adds output underrun_count[15:0], a saturating count of underrun events.
  - Cleared by reset and clear_status; an increment in the same cycle as clear_status yields 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, channels=4, write 256-word burst 0x0000..0x00FF, strobe every 8 cycles: first tx_valid gives i0=0x0000, q0=0x0001, i1=0x0002, q1=0x0003; 64 vectors in order; no flags set.
- 257-word burst: fifo_level peaks at 256; word 257 is never output; tx_overflow stays 0.
- Fill with AWIDTH=11, no strobes: 2048 words accepted; have_space falls when level reaches 1792; further write sets tx_overflow; clear_status clears it.
- channels=4, burst of 3 words, then new burst starting 0xA000: sync_err=1; next vector has i0=0xA000.
- txstrobe with FIFO empty: tx_underrun=1, tx_data unchanged, no tx_valid. With macro, 3 such strobes give underrun_count=3; strobe plus clear_status in the same cycle leaves tx_underrun=1.
- channels=2 with NUM_CHAN=4: slots 2..7 read 0; strobe and refill in the same cycle lose no words.
